// File: rtl/axi_byte_initiator.sv
// Byte request to single-beat 64-bit AXI bridge with a one-line read buffer.
// Hits answer the cycle after accept; misses and writes go through AR/R or AW+W/B, then a one-cycle response.
module axi_byte_initiator #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          ADDR_W      = 23,
  parameter bit          LINE_BUF_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  input  logic              clear_error,
  output logic              error,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  output logic [31:0]       axi_araddr,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  input  logic [63:0]       axi_rdata,
  input  logic [1:0]        axi_rresp,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [31:0]       axi_awaddr,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  output logic [63:0]       axi_wdata,
  output logic [7:0]        axi_wstrb,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  input  logic [1:0]        axi_bresp
);
  localparam int TAG_W = ADDR_W - 3;

  typedef enum logic [2:0] {IDLE, AR, R, WR, B, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              aw_done, w_done;
  logic [63:0]       line_buf;
  logic [TAG_W-1:0]  line_tag;
  logic              line_vld;
  logic [7:0]        rdata_q;
  logic              error_q;

  logic        accept, hit, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [2:0]  lane_q;
  logic [31:0] line_addr;

  assign accept = req_valid && (state == IDLE);
  assign hit    = LINE_BUF_EN && line_vld && !req_write && (line_tag == req_addr[ADDR_W-1:3]);
  assign ar_hs  = axi_arvalid && axi_arready;
  assign r_hs   = axi_rvalid && axi_rready;
  assign aw_hs  = axi_awvalid && axi_awready;
  assign w_hs   = axi_wvalid && axi_wready;
  assign b_hs   = axi_bvalid && axi_bready;
  assign lane_q = addr_q[2:0];
  assign line_addr = BASE_ADDR + {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W-1:3], 3'b000};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = req_write ? WR : (hit ? RESP : AR);
      AR:   if (axi_arready) state_nxt = R;
      R:    if (axi_rvalid) state_nxt = RESP;
      WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = B;
      B:    if (axi_bvalid) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == IDLE);
    rsp_valid   = (state == RESP);
    axi_arvalid = (state == AR);
    axi_rready  = (state == R);
    axi_awvalid = (state == WR) && !aw_done;
    axi_wvalid  = (state == WR) && !w_done;
    axi_bready  = (state == B);
    axi_araddr  = line_addr;
    axi_awaddr  = line_addr;
    axi_wdata   = {8{wdata_q}};
    axi_wstrb   = 8'd1 << lane_q;
  end

  assign rsp_rdata = rdata_q;
  assign error     = error_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      line_buf <= '0;
      line_tag <= '0;
      line_vld <= 1'b0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (hit) rdata_q <= line_buf[{req_addr[2:0], 3'b000} +: 8];
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (r_hs) begin
        line_buf <= axi_rdata;
        line_tag <= addr_q[ADDR_W-1:3];
        line_vld <= (axi_rresp == 2'b00);
        rdata_q  <= (axi_rresp == 2'b00) ? axi_rdata[{lane_q, 3'b000} +: 8] : 8'hFF;
      end
      // A failed write leaves the buffered copy of unknown coherence, so drop it.
      if (b_hs && line_vld && (line_tag == addr_q[ADDR_W-1:3])) begin
        if (axi_bresp == 2'b00) line_buf[{lane_q, 3'b000} +: 8] <= wdata_q;
        else                    line_vld <= 1'b0;
      end
      if ((r_hs && axi_rresp != 2'b00) || (b_hs && axi_bresp != 2'b00)) error_q <= 1'b1;
      else if (clear_error)                                             error_q <= 1'b0;
    end
  end
endmodule
